int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_pkg.sv | 24 ++
 rtl/int_ctrl_prio_enc.sv | 27 ++
 rtl/int_ctrl.sv | 131 +++++++++++++
 tb/tb_int_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the int_ctrl block.
package int_ctrl_pkg;

  // Fixed vectors: channel 0 (non-maskable) and the shared maskable vector.
  localparam logic [15:0] NMI_VEC = 16'hFFFA;
  localparam logic [15:0] IRQ_VEC = 16'hFFFE;

  // Arbitration state: IDLE waits for a poll, TAKEN waits for the ack.
  typedef enum logic {
    IDLE  = 1'b0,
    TAKEN = 1'b1
  } state_t;

  // Ceiling log2, used to size the channel id (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: the lowest-index asserted request wins.
module int_ctrl_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = clog2(N)
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scan from the top down so the lowest asserted index is the last write.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path
    // through this block can leave a value unassigned and infer a latch.
    valid = 1'b0;
    id    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        valid = 1'b1;
        id    = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge/level request capture, mask and I-flag gating,
// fixed-priority arbitration at CPU poll points, and vector address lookup.
// Optional feature macro: INT_CTRL_VECTORED_EN gives each maskable channel
// its own vector at VEC_BASE + 2*(k-1); otherwise they share IRQ_VEC.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int          NUM_SRC  = 4,
  parameter logic [15:0] VEC_BASE = 16'hFFE0,
  localparam int         ID_W     = clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] edge_mode,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               i_flag,
  input  logic               poll,
  input  logic               ack,
  output logic               irq_take,
  output logic               nmi_class,
  output logic [ID_W-1:0]    vec_id,
  output logic [15:0]        vec_addr,
  output logic [NUM_SRC-1:0] pending
);

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] eligible;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic               take_d;
  logic               nmi_d;
  logic [ID_W-1:0]    id_d;
  logic               ack_clr;

  // The acknowledge only counts while an interrupt is actually taken.
  assign ack_clr = (state_q == TAKEN) && ack;

  // Channel 0 ignores mask and I-flag; the others need both to allow it.
  assign eligible = {pending[NUM_SRC-1:1] & mask[NUM_SRC-1:1] & {(NUM_SRC-1){~i_flag}},
                     pending[0]};

  int_ctrl_prio_enc #(
    .N    (NUM_SRC),
    .ID_W (ID_W)
  ) u_prio_enc (
    .req   (eligible),
    .valid (win_valid),
    .id    (win_id)
  );

  // Next pending: edge channels latch rises and clear on their own ack
  // (a simultaneous rise wins); level channels simply follow the line.
  always_comb begin
    pending_d = pending;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (edge_mode[k]) begin
        if (ack_clr && (int'(vec_id) == k)) pending_d[k] = 1'b0;
        if (src[k] && !src_d[k])            pending_d[k] = 1'b1;
      end else begin
        pending_d[k] = src[k];
      end
    end
  end

  // Next state and registered outputs; TAKEN freezes arbitration until ack.
  always_comb begin
    state_d = state_q;
    take_d  = irq_take;
    nmi_d   = nmi_class;
    id_d    = vec_id;
    unique case (state_q)
      IDLE: begin
        if (poll && win_valid) begin
          state_d = TAKEN;
          take_d  = 1'b1;
          id_d    = win_id;
          nmi_d   = (win_id == '0);
        end
      end
      TAKEN: begin
        if (ack) begin
          state_d = IDLE;
          take_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers: synchronous reset first, then advance only on ce.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= IDLE;
      src_d     <= '0;
      pending   <= '0;
      irq_take  <= 1'b0;
      nmi_class <= 1'b0;
      vec_id    <= '0;
    end else if (ce) begin
      state_q   <= state_d;
      src_d     <= src;
      pending   <= pending_d;
      irq_take  <= take_d;
      nmi_class <= nmi_d;
      vec_id    <= id_d;
    end
  end

`ifdef INT_CTRL_VECTORED_EN
  // Per-channel vector table for maskable channels; channel 0 stays fixed.
  always_comb begin
    vec_addr = NMI_VEC;
    if (vec_id != '0) vec_addr = VEC_BASE + ((16'(vec_id) - 16'd1) << 1);
  end
`else
  // All maskable channels share one vector; the table base is not used.
  always_comb begin
    vec_addr = (vec_id == '0) ? NMI_VEC : IRQ_VEC;
  end

  logic [15:0] unused_vec_base;
  assign unused_vec_base = VEC_BASE;
`endif

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus a randomized run,
// all checked against a behavioural model of the controller's rules.
module tb_int_ctrl;

  localparam int          N    = 4;
  localparam logic [15:0] BASE = 16'hFFE0;

  logic         clk = 1'b0;
  logic         reset, ce, i_flag, poll, ack;
  logic [N-1:0] src, edge_mode, mask;
  logic         irq_take, nmi_class;
  logic [1:0]   vec_id;
  logic [15:0]  vec_addr;
  logic [N-1:0] pending;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [N-1:0] m_pend, m_prev;
  logic         m_busy, m_nmi;
  logic [1:0]   m_id;

  int_ctrl #(.NUM_SRC(N), .VEC_BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .src       (src),
    .edge_mode (edge_mode),
    .mask      (mask),
    .i_flag    (i_flag),
    .poll      (poll),
    .ack       (ack),
    .irq_take  (irq_take),
    .nmi_class (nmi_class),
    .vec_id    (vec_id),
    .vec_addr  (vec_addr),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_addr(input logic [1:0] id);
    if (id == 2'd0) return 16'hFFFA;
`ifdef INT_CTRL_VECTORED_EN
    return BASE + 16'(2 * (int'(id) - 1));
`else
    return 16'hFFFE;
`endif
  endfunction

  // One clock: advance the model from the rules, then settle past the edge.
  task automatic tick();
    logic [N-1:0] np;
    logic         found;
    @(posedge clk);
    if (reset) begin
      m_pend = '0; m_prev = '0; m_busy = 1'b0; m_nmi = 1'b0; m_id = '0;
    end else if (ce) begin
      for (int k = 0; k < N; k++) begin
        if (edge_mode[k])
          np[k] = (src[k] && !m_prev[k]) ||
                  (m_pend[k] && !(m_busy && ack && int'(m_id) == k));
        else
          np[k] = src[k];
      end
      if (m_busy) begin
        if (ack) m_busy = 1'b0;
      end else if (poll) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && m_pend[k] && (k == 0 || (mask[k] && !i_flag))) begin
            found = 1'b1; m_busy = 1'b1; m_id = 2'(k); m_nmi = (k == 0);
          end
        end
      end
      m_pend = np;
      m_prev = src;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; src = '0; edge_mode = '1; mask = '1;
    i_flag = 1'b0; poll = 1'b0; ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    total++; if (irq_take !== 1'b0) begin bad++; $display("FAIL reset_take got=%b want=0", irq_take); end
    total++; if (nmi_class !== 1'b0) begin bad++; $display("FAIL reset_nmi got=%b want=0", nmi_class); end
    total++; if (vec_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", vec_id); end
    total++; if (vec_addr !== 16'hFFFA) begin bad++; $display("FAIL reset_addr got=%h want=fffa", vec_addr); end
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL reset_pend got=%b want=0000", pending); end
    ack = 1'b1; tick(); ack = 1'b0;
    total++; if (irq_take !== 1'b0) begin bad++; $display("FAIL idle_ack got=%b want=0", irq_take); end
  endtask

  task automatic test_basic();
    src = 4'b0100; tick(); src = '0; tick();
    total++; if (pending !== 4'b0100) begin bad++; $display("FAIL basic_pend got=%b want=0100", pending); end
    poll = 1'b1; tick(); poll = 1'b0;
    total++; if (irq_take !== 1'b1 || vec_id !== 2'd2) begin bad++; $display("FAIL basic_take got=%b/%0d want=1/2", irq_take, vec_id); end
    total++; if (vec_addr !== exp_addr(2'd2)) begin bad++; $display("FAIL basic_addr got=%h want=%h", vec_addr, exp_addr(2'd2)); end
    ack = 1'b1; tick(); ack = 1'b0;
    total++; if (irq_take !== 1'b0 || pending[2] !== 1'b0) begin bad++; $display("FAIL basic_ack got=%b/%b want=0/0", irq_take, pending[2]); end
  endtask

  task automatic test_priority();
    src = 4'b0011; tick(); src = '0; tick();
    poll = 1'b1; tick(); poll = 1'b0;
    total++; if (vec_id !== 2'd0 || nmi_class !== 1'b1 || vec_addr !== 16'hFFFA) begin bad++; $display("FAIL prio_nmi got=%0d/%b/%h want=0/1/fffa", vec_id, nmi_class, vec_addr); end
    ack = 1'b1; tick(); ack = 1'b0;
    poll = 1'b1; tick(); poll = 1'b0;
    total++; if (irq_take !== 1'b1 || vec_id !== 2'd1 || nmi_class !== 1'b0) begin bad++; $display("FAIL prio_ch1 got=%b/%0d/%b want=1/1/0", irq_take, vec_id, nmi_class); end
    ack = 1'b1; tick(); ack = 1'b0;
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL prio_clear got=%b want=0000", pending); end
  endtask

  task automatic test_iflag();
    i_flag = 1'b1; src = 4'b1000; tick(); src = '0; tick();
    poll = 1'b1; tick(); poll = 1'b0;
    total++; if (irq_take !== 1'b0 || pending[3] !== 1'b1) begin bad++; $display("FAIL iflag_block got=%b/%b want=0/1", irq_take, pending[3]); end
    i_flag = 1'b0; poll = 1'b1; tick(); poll = 1'b0;
    total++; if (irq_take !== 1'b1 || vec_id !== 2'd3) begin bad++; $display("FAIL iflag_take got=%b/%0d want=1/3", irq_take, vec_id); end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_level();
    edge_mode = 4'b1101; src = 4'b0010; tick();
    total++; if (pending[1] !== 1'b1) begin bad++; $display("FAIL level_pend got=%b want=1", pending[1]); end
    poll = 1'b1; tick(); poll = 1'b0;
    total++; if (irq_take !== 1'b1 || vec_id !== 2'd1) begin bad++; $display("FAIL level_take got=%b/%0d want=1/1", irq_take, vec_id); end
    ack = 1'b1; tick(); ack = 1'b0;
    total++; if (irq_take !== 1'b0 || pending[1] !== 1'b1) begin bad++; $display("FAIL level_ack got=%b/%b want=0/1", irq_take, pending[1]); end
    poll = 1'b1; tick(); poll = 1'b0;
    total++; if (irq_take !== 1'b1 || vec_id !== 2'd1) begin bad++; $display("FAIL level_retake got=%b/%0d want=1/1", irq_take, vec_id); end
    ack = 1'b1; tick(); ack = 1'b0;
    src = '0; tick();
    total++; if (pending[1] !== 1'b0) begin bad++; $display("FAIL level_drop got=%b want=0", pending[1]); end
    edge_mode = '1;
  endtask

  task automatic test_frozen();
    src = 4'b0100; tick(); src = '0; tick();
    poll = 1'b1; tick(); poll = 1'b0;
    src = 4'b0001; poll = 1'b1; mask = 4'b0000; i_flag = 1'b1; tick();
    src = '0; poll = 1'b0;
    total++; if (irq_take !== 1'b1 || vec_id !== 2'd2 || nmi_class !== 1'b0) begin bad++; $display("FAIL frozen_hold got=%b/%0d/%b want=1/2/0", irq_take, vec_id, nmi_class); end
    total++; if (pending !== 4'b0101) begin bad++; $display("FAIL frozen_accum got=%b want=0101", pending); end
    mask = '1; i_flag = 1'b0; tick();
    ack = 1'b1; src = 4'b0100; tick(); ack = 1'b0; src = '0;
    total++; if (irq_take !== 1'b0 || pending[2] !== 1'b1) begin bad++; $display("FAIL ack_setwins got=%b/%b want=0/1", irq_take, pending[2]); end
    poll = 1'b1; tick(); poll = 1'b0;
    total++; if (vec_id !== 2'd0 || nmi_class !== 1'b1) begin bad++; $display("FAIL frozen_next got=%0d/%b want=0/1", vec_id, nmi_class); end
    ack = 1'b1; tick(); ack = 1'b0;
    poll = 1'b1; tick(); poll = 1'b0; ack = 1'b1; tick(); ack = 1'b0;
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL frozen_drain got=%b want=0000", pending); end
  endtask

  task automatic test_ce_hold();
    src = 4'b0100; tick(); src = '0; tick();
    poll = 1'b1; tick(); poll = 1'b0;
    ce = 1'b0;
    src = 4'b0010; tick();
    src = '0; poll = 1'b1; tick();
    poll = 1'b0; ack = 1'b1; tick();
    ack = 1'b0; tick();
    total++; if (irq_take !== 1'b1 || vec_id !== 2'd2 || pending !== 4'b0100) begin bad++; $display("FAIL ce_hold got=%b/%0d/%b want=1/2/0100", irq_take, vec_id, pending); end
    ce = 1'b1; tick();
    total++; if (irq_take !== 1'b1 || pending !== 4'b0100) begin bad++; $display("FAIL ce_resume got=%b/%b want=1/0100", irq_take, pending); end
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (irq_take !== 1'b0 || nmi_class !== 1'b0 || vec_id !== 2'd0 || vec_addr !== 16'hFFFA || pending !== 4'b0000)
      begin bad++; $display("FAIL taken_reset got=%b/%b/%0d/%h/%b want=0/0/0/fffa/0000", irq_take, nmi_class, vec_id, vec_addr, pending); end
  endtask

  task automatic test_reset_edge();
    reset = 1'b1; src = 4'b0100; tick(); reset = 1'b0;
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL rst_hold got=%b want=0000", pending); end
    tick();
    total++; if (pending !== 4'b0100) begin bad++; $display("FAIL rst_edge got=%b want=0100", pending); end
    src = '0; poll = 1'b1; tick(); poll = 1'b0; ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_random();
    int shown = 0;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(99) == 0);
      ce        = ($urandom_range(9) != 0);
      src       = N'($urandom);
      if ($urandom_range(15) == 0) edge_mode = N'($urandom);
      mask      = N'($urandom);
      i_flag    = ($urandom_range(3) == 0);
      poll      = ($urandom_range(2) == 0);
      ack       = ($urandom_range(2) == 0);
      tick();
      total++; if (irq_take !== m_busy) begin bad++; if (shown++ < 30) $display("FAIL rnd_take c=%0d got=%b want=%b", c, irq_take, m_busy); end
      total++; if (pending !== m_pend) begin bad++; if (shown++ < 30) $display("FAIL rnd_pend c=%0d got=%b want=%b", c, pending, m_pend); end
      total++; if (vec_id !== m_id) begin bad++; if (shown++ < 30) $display("FAIL rnd_id c=%0d got=%0d want=%0d", c, vec_id, m_id); end
      total++; if (nmi_class !== m_nmi) begin bad++; if (shown++ < 30) $display("FAIL rnd_nmi c=%0d got=%b want=%b", c, nmi_class, m_nmi); end
      total++; if (vec_addr !== exp_addr(m_id)) begin bad++; if (shown++ < 30) $display("FAIL rnd_addr c=%0d got=%h want=%h", c, vec_addr, exp_addr(m_id)); end
    end
  endtask

  initial begin
    m_pend = '0; m_prev = '0; m_busy = 1'b0; m_nmi = 1'b0; m_id = '0;
    test_reset();
    test_basic();
    test_priority();
    test_iflag();
    test_level();
    test_frozen();
    test_ce_hold();
    test_reset_edge();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
